// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that runs byte-level I2CMB commands for two round-robin requesters.
// Build option I2CMB_SEQ_IRQ_EN: wait for irq_i instead of polling CMDR.
module i2cmb_cmd_sequencer #(
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  CSR_INIT_IRQ   = 8'hC0,
    parameter logic [7:0]  CSR_INIT_POLL  = 8'h80
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    input  logic [5:0]  req_cmd_i,
    input  logic [15:0] req_data_i,
    output logic [1:0]  req_ready_o,
    output logic [1:0]  rsp_valid_o,
    output logic [4:0]  rsp_status_o,
    output logic [7:0]  rsp_data_o,
    output logic        owner_o,
    output logic        busy_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [1:0]  adr_o,
    output logic [7:0]  dat_o,
    input  logic [7:0]  dat_i,
    input  logic        ack_i,
    input  logic        irq_i
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [2:0] CMD_WAIT = 3'b000, CMD_WRITE = 3'b001, CMD_RD_ACK = 3'b010,
                           CMD_RD_NAK = 3'b011, CMD_START = 3'b100, CMD_STOP = 3'b101,
                           CMD_SET_BUS = 3'b110, CMD_BAD = 3'b111;
`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_INIT = CSR_INIT_IRQ;
`else
    localparam logic [7:0] CSR_INIT = CSR_INIT_POLL;
    localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    logic [GW-1:0] r_gap, n_gap;
    logic          w_unused_irq;
    assign w_unused_irq = irq_i;
`endif

    typedef enum logic [2:0] {
        S_INIT_CSR, S_IDLE, S_WR_DPR, S_WR_CMDR, S_WAIT_DONE, S_RD_CMDR, S_RD_DPR, S_RESP
    } state_t;

    state_t        r_state, n_state;
    logic          r_cyc, n_cyc, r_we, n_we;
    logic [1:0]    r_adr, n_adr;
    logic [7:0]    r_dat, n_dat;
    logic [1:0]    r_ready, n_ready, r_rsp_valid, n_rsp_valid;
    logic [4:0]    r_status, n_status;
    logic [7:0]    r_rsp_data, n_rsp_data;
    logic          r_owner, n_owner, r_lock, n_lock, r_rr, n_rr, r_busy, n_busy;
    logic [2:0]    r_cmd, n_cmd;
    logic [7:0]    r_data, n_data;
    logic [3:0]    r_stat, n_stat;
    logic [TW-1:0] r_tmo, n_tmo;
    logic          w_ack, w_fin, w_grant, w_g;
    logic [4:0]    w_fin_status;

    // Next-state, bus sequencing and response generation.
    always_comb begin
        n_state = r_state; n_cyc = r_cyc; n_we = r_we; n_adr = r_adr; n_dat = r_dat;
        n_ready = 2'b00; n_rsp_valid = 2'b00; n_status = 5'b0; n_rsp_data = 8'h00;
        n_owner = r_owner; n_lock = r_lock; n_rr = r_rr;
        n_cmd = r_cmd; n_data = r_data; n_stat = r_stat; n_tmo = r_tmo;
`ifndef I2CMB_SEQ_IRQ_EN
        n_gap = r_gap;
`endif
        w_fin = 1'b0; w_fin_status = 5'b0; w_grant = 1'b0; w_g = 1'b0;
        w_ack = r_cyc & ack_i;
        if (w_ack) n_cyc = 1'b0;

        case (r_state)
            S_INIT_CSR: begin
                if (!r_cyc) begin
                    n_cyc = 1'b1; n_we = 1'b1; n_adr = ADR_CSR; n_dat = CSR_INIT;
                end else if (ack_i) begin
                    n_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_lock) begin
                    w_grant = req_valid_i[r_owner]; w_g = r_owner;
                end else if (req_valid_i[r_rr]) begin
                    w_grant = 1'b1; w_g = r_rr;
                end else if (req_valid_i[~r_rr]) begin
                    w_grant = 1'b1; w_g = ~r_rr;
                end
                if (w_grant) begin
                    n_ready = w_g ? 2'b10 : 2'b01;
                    n_owner = w_g;
                    n_rr    = ~w_g;
                    n_cmd   = w_g ? req_cmd_i[5:3] : req_cmd_i[2:0];
                    n_data  = w_g ? req_data_i[15:8] : req_data_i[7:0];
                    n_tmo   = '0;
                    if (n_cmd == CMD_BAD) begin
                        w_fin = 1'b1; w_fin_status = 5'b00001;
                    end else if (n_cmd == CMD_WRITE || n_cmd == CMD_WAIT || n_cmd == CMD_SET_BUS) begin
                        n_state = S_WR_DPR;
                    end else begin
                        n_state = S_WR_CMDR;
                    end
                end
            end
            S_WR_DPR: begin
                if (!r_cyc) begin
                    n_cyc = 1'b1; n_we = 1'b1; n_adr = ADR_DPR; n_dat = r_data;
                end else if (ack_i) begin
                    n_state = S_WR_CMDR;
                end
            end
            S_WR_CMDR: begin
                if (!r_cyc) begin
                    n_cyc = 1'b1; n_we = 1'b1; n_adr = ADR_CMDR; n_dat = {5'b0, r_cmd};
                end else if (ack_i) begin
                    n_state = S_WAIT_DONE;
                    n_tmo   = '0;
`ifndef I2CMB_SEQ_IRQ_EN
                    n_gap   = '0;
`endif
                end
            end
            S_WAIT_DONE: begin
                n_tmo = r_tmo + TW'(1);
                if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
                    // Abandon any poll in flight; the core is presumed hung.
                    n_cyc = 1'b0; w_fin = 1'b1; w_fin_status = 5'b10000;
                end else begin
`ifdef I2CMB_SEQ_IRQ_EN
                    if (irq_i) n_state = S_RD_CMDR;
`else
                    if (r_cyc) begin
                        if (ack_i) begin
                            n_gap = GW'(POLL_GAP);
                            if (dat_i[7:4] != 4'h0) n_state = S_RD_CMDR;
                        end
                    end else if (r_gap == '0) begin
                        n_cyc = 1'b1; n_we = 1'b0; n_adr = ADR_CMDR; n_dat = 8'h00;
                    end else begin
                        n_gap = r_gap - GW'(1);
                    end
`endif
                end
            end
            S_RD_CMDR: begin
                if (!r_cyc) begin
                    n_cyc = 1'b1; n_we = 1'b0; n_adr = ADR_CMDR; n_dat = 8'h00;
                end else if (ack_i) begin
                    n_stat = dat_i[7:4];
                    if (r_cmd == CMD_RD_ACK || r_cmd == CMD_RD_NAK) begin
                        n_state = S_RD_DPR;
                    end else begin
                        w_fin = 1'b1; w_fin_status = {1'b0, dat_i[7:4]};
                    end
                end
            end
            S_RD_DPR: begin
                if (!r_cyc) begin
                    n_cyc = 1'b1; n_we = 1'b0; n_adr = ADR_DPR; n_dat = 8'h00;
                end else if (ack_i) begin
                    w_fin = 1'b1; w_fin_status = {1'b0, r_stat};
                end
            end
            S_RESP:  n_state = S_IDLE;
            default: n_state = S_INIT_CSR;
        endcase

        // Completion: pulse the owner and update the START..STOP lock.
        if (w_fin) begin
            n_state     = S_RESP;
            n_rsp_valid = n_owner ? 2'b10 : 2'b01;
            n_status    = w_fin_status;
            if (r_state == S_RD_DPR) n_rsp_data = dat_i;
            if (w_fin_status[4] | w_fin_status[1] | w_fin_status[0]) n_lock = 1'b0;
            else if (n_cmd == CMD_STOP) n_lock = 1'b0;
            else if (n_cmd == CMD_START && w_fin_status[3]) n_lock = 1'b1;
        end
        n_busy = (n_state != S_IDLE) || n_lock;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_INIT_CSR; r_cyc <= 1'b0; r_we <= 1'b0; r_adr <= 2'b0; r_dat <= 8'h00;
            r_ready <= 2'b00; r_rsp_valid <= 2'b00; r_status <= 5'b0; r_rsp_data <= 8'h00;
            r_owner <= 1'b0; r_lock <= 1'b0; r_rr <= 1'b0; r_busy <= 1'b0;
            r_cmd <= 3'b0; r_data <= 8'h00; r_stat <= 4'h0; r_tmo <= '0;
`ifndef I2CMB_SEQ_IRQ_EN
            r_gap <= '0;
`endif
        end else begin
            r_state <= n_state; r_cyc <= n_cyc; r_we <= n_we; r_adr <= n_adr; r_dat <= n_dat;
            r_ready <= n_ready; r_rsp_valid <= n_rsp_valid; r_status <= n_status;
            r_rsp_data <= n_rsp_data; r_owner <= n_owner; r_lock <= n_lock; r_rr <= n_rr;
            r_busy <= n_busy; r_cmd <= n_cmd; r_data <= n_data; r_stat <= n_stat; r_tmo <= n_tmo;
`ifndef I2CMB_SEQ_IRQ_EN
            r_gap <= n_gap;
`endif
        end
    end

    assign req_ready_o  = r_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_status_o = r_status;
    assign rsp_data_o   = r_rsp_data;
    assign owner_o      = r_owner;
    assign busy_o       = r_busy;
    assign cyc_o        = r_cyc;
    assign stb_o        = r_cyc;
    assign we_o         = r_we;
    assign adr_o        = r_adr;
    assign dat_o        = r_dat;
endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer: behavioural I2CMB slave plus write/response scoreboards.
module tb_i2cmb_cmd_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [5:0]  req_cmd_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_ready_o, rsp_valid_o;
    logic [4:0]  rsp_status_o;
    logic [7:0]  rsp_data_o, dat_o, dat_i;
    logic        owner_o, busy_o, cyc_o, stb_o, we_o, ack_i, irq_i;
    logic [1:0]  adr_o;

`ifdef I2CMB_SEQ_IRQ_EN
    localparam logic [7:0] CSR_EXP = 8'hC0;
`else
    localparam logic [7:0] CSR_EXP = 8'h80;
`endif
    localparam int BOUND = 3000;

    i2cmb_cmd_sequencer #(.POLL_GAP(2), .TIMEOUT_CYCLES(300)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i),
        .req_data_i(req_data_i), .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_status_o(rsp_status_o), .rsp_data_o(rsp_data_o), .owner_o(owner_o),
        .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0, n_fail = 0, rsp_cnt = 0, lock_need = 0;
    logic [9:0]  wr_q[$];
    logic [14:0] rsp_q[$];
    logic csr_seen = 1'b0, served1 = 1'b0, lock_phase = 1'b0;
    logic never_done, done, irq_clr;
    logic [7:0] done_val, rd_dpr;
    logic [3:0] cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: registered ack, done bits appear a few cycles after each CMDR write.
    always @(posedge clk_i) begin
        if (rst_i) begin
            ack_i <= 1'b0; cnt <= 4'd0; done <= 1'b0; irq_clr <= 1'b0;
        end else begin
            ack_i <= cyc_o && stb_o && !ack_i;
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && !never_done) done <= 1'b1;
            end
            if (cyc_o && ack_i && adr_o == 2'd2) begin
                if (we_o) begin done <= 1'b0; irq_clr <= 1'b0; cnt <= 4'd4; end
                else if (done) irq_clr <= 1'b1;
            end
        end
    end
    assign irq_i = done & ~irq_clr;
    assign dat_i = (adr_o == 2'd2) ? (done ? done_val : 8'h00) : (adr_o == 2'd1) ? rd_dpr : 8'h00;

    // Monitor: writes, responses and grant rules.
    always @(negedge clk_i) begin
        if (rst_i) csr_seen = 1'b0;
        else begin
            if (cyc_o && ack_i && we_o) begin
                if (adr_o == 2'd0) csr_seen = 1'b1;
                if (wr_q.size() == 0) check("wb_wr_expected", 32'(wr_q.size()), 32'd1);
                else check("wb_wr", 32'({adr_o, dat_o}), 32'(wr_q.pop_front()));
            end
            if (rsp_valid_o != 2'b00) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) check("rsp_expected", 32'(rsp_q.size()), 32'd1);
                else check("rsp", 32'({rsp_valid_o, rsp_status_o, rsp_data_o}), 32'(rsp_q.pop_front()));
            end
            if (req_ready_o != 2'b00) begin
                check("ready_after_init", 32'(csr_seen), 32'd1);
                check("ready_onehot", 32'($countones(req_ready_o)), 32'd1);
                if (req_ready_o[1]) begin
                    served1 = 1'b1;
                    if (lock_phase) check("lock_hold", 32'(rsp_cnt >= lock_need), 32'd1);
                end
            end
        end
    end

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    task automatic expect_cmd(input int r, input logic [2:0] cmd, input logic [7:0] d,
                              input logic [4:0] st, input logic [7:0] rd);
        if (cmd != 3'b111) begin
            if (cmd == 3'b000 || cmd == 3'b001 || cmd == 3'b110) push_wr(2'd1, d);
            push_wr(2'd2, {5'b0, cmd});
        end
        rsp_q.push_back({(r == 1) ? 2'b10 : 2'b01, st, rd});
    endtask

    task automatic issue(input int r, input logic [2:0] cmd, input logic [7:0] d);
        int n = 0;
        req_cmd_i[r*3 +: 3]  = cmd;
        req_data_i[r*8 +: 8] = d;
        req_valid_i[r]       = 1'b1;
        while (n < BOUND && !req_ready_o[r]) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= BOUND) check("ready_timeout", 32'(req_ready_o[r]), 32'd1);
        req_valid_i[r] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < BOUND) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= BOUND) check("drain_timeout", 32'(rsp_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 2'b00; req_cmd_i = 6'b0; req_data_i = 16'h0;
        never_done = 1'b0; done_val = 8'h80; rd_dpr = 8'h3C;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_adr_dat", 32'({adr_o, dat_o}), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp", 32'({rsp_valid_o, rsp_status_o, rsp_data_o}), 32'd0);
        check("rst_busy_owner", 32'({busy_o, owner_o}), 32'd0);

        // Simultaneous requests right out of reset: req0 first, then req1.
        push_wr(2'd0, CSR_EXP);
        expect_cmd(0, 3'b110, 8'h05, 5'b01000, 8'h00);
        expect_cmd(1, 3'b011, 8'h00, 5'b01000, 8'h3C);
        rst_i = 1'b0;
        fork
            issue(0, 3'b110, 8'h05);
            issue(1, 3'b011, 8'h00);
        join
        drain();

        // START locks req0; req1 waits until the STOP completes.
        expect_cmd(0, 3'b100, 8'h00, 5'b01000, 8'h00);
        issue(0, 3'b100, 8'h00);
        drain();
        @(negedge clk_i);
        check("lock_busy", 32'(busy_o), 32'd1);
        check("lock_owner", 32'(owner_o), 32'd0);
        expect_cmd(0, 3'b101, 8'h00, 5'b01000, 8'h00);
        expect_cmd(1, 3'b001, 8'hA5, 5'b01000, 8'h00);
        lock_need = rsp_cnt + 1; served1 = 1'b0; lock_phase = 1'b1;
        fork
            issue(1, 3'b001, 8'hA5);
            begin
                repeat (60) @(negedge clk_i);
                check("lock_blocked", 32'(served1), 32'd0);
                issue(0, 3'b101, 8'h00);
            end
        join
        drain();
        lock_phase = 1'b0;
        @(negedge clk_i);
        check("unlock_busy", 32'(busy_o), 32'd0);

        // Illegal command, arbitration-lost START, NAK'd WRITE.
        expect_cmd(0, 3'b111, 8'h00, 5'b00001, 8'h00);
        issue(0, 3'b111, 8'h00);
        drain();
        done_val = 8'h20;
        expect_cmd(1, 3'b100, 8'h00, 5'b00010, 8'h00);
        issue(1, 3'b100, 8'h00);
        drain();
        @(negedge clk_i);
        check("al_no_lock", 32'(busy_o), 32'd0);
        done_val = 8'h40;
        expect_cmd(0, 3'b001, 8'h3E, 5'b00100, 8'h00);
        issue(0, 3'b001, 8'h3E);
        drain();
        done_val = 8'h80;

        // Timeout while locked releases the lock.
        expect_cmd(0, 3'b100, 8'h00, 5'b01000, 8'h00);
        issue(0, 3'b100, 8'h00);
        drain();
        never_done = 1'b1;
        expect_cmd(0, 3'b001, 8'h5A, 5'b10000, 8'h00);
        issue(0, 3'b001, 8'h5A);
        drain();
        never_done = 1'b0;
        @(negedge clk_i);
        check("tmo_unlock", 32'(busy_o), 32'd0);
        expect_cmd(1, 3'b001, 8'h77, 5'b01000, 8'h00);
        issue(1, 3'b001, 8'h77);
        drain();

        // Reset during WAIT_DONE: bus drops, no response, re-init.
        never_done = 1'b1;
        push_wr(2'd1, 8'h99);
        push_wr(2'd2, 8'h01);
        issue(0, 3'b001, 8'h99);
        drain();
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_cyc", 32'(cyc_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        push_wr(2'd0, CSR_EXP);
        never_done = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        expect_cmd(1, 3'b001, 8'h12, 5'b01000, 8'h00);
        issue(1, 3'b001, 8'h12);
        drain();
        repeat (20) @(negedge clk_i);
        check("final_queues", 32'(wr_q.size() + rsp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
